// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like memory port between fetch and data requesters, one transaction in flight
module mem_req_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  state_t state;
  logic ownerData;
  logic [CW-1:0] starveCnt;
  logic grantData, grantInst, respond;
  // data wins unless fetch has waited out its allowance of data grants
  always_comb begin
    grantData = state == IDLE && data_req && !(inst_req && starveCnt == LIMIT);
    grantInst = state == IDLE && inst_req && !grantData;
    respond   = state == WAIT && mem_data_ok;
  end
  assign inst_addr_ok = grantInst;
  assign data_addr_ok = grantData;
  assign inst_data_ok = respond && !ownerData;
  assign data_data_ok = respond && ownerData;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ownerData <= 1'b0;
      starveCnt <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (grantData || grantInst) begin
          state     <= REQ;
          mem_req   <= 1'b1;
          busy      <= 1'b1;
          ownerData <= grantData;
          mem_wr    <= grantData && data_wr;
          mem_size  <= grantData ? data_size : 2'b10;
          mem_addr  <= grantData ? data_addr : inst_addr;
          mem_wdata <= grantData ? data_wdata : '0;
          starveCnt <= grantInst ? '0 : (inst_req && starveCnt != LIMIT) ? starveCnt + 1'b1 : starveCnt;
        end
        REQ: if (mem_addr_ok) begin
          state   <= WAIT;
          mem_req <= 1'b0;
        end
        WAIT: if (mem_data_ok) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed checks of grant priority, starvation bound, handshakes and reset
module tb_mem_req_arbiter;
  logic clk = 0, rst = 1;
  logic inst_req = 0, data_req = 0, data_wr = 0, mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [1:0] data_size = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr, busy;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_size;
  int nCmp = 0, nBad = 0;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one full transaction with both requesters held high; checks who wins
  task automatic runTxn(input string tag, input logic expData);
    #4;
    checkVal({tag, "_data_addr_ok"}, data_addr_ok, expData);
    checkVal({tag, "_inst_addr_ok"}, inst_addr_ok, !expData);
    tick;
    mem_addr_ok = 1;
    #4;
    checkVal({tag, "_mem_req"}, mem_req, 1);
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    #4;
    checkVal({tag, "_data_data_ok"}, data_data_ok, expData);
    checkVal({tag, "_inst_data_ok"}, inst_data_ok, !expData);
    tick;
    mem_data_ok = 0;
  endtask

  initial begin
    tick;
    tick;
    rst = 0;
    #4;
    checkVal("rst_busy", busy, 0);
    checkVal("rst_mem_req", mem_req, 0);
    checkVal("rst_mem_wr", mem_wr, 0);
    checkVal("rst_mem_addr", mem_addr, 0);
    checkVal("rst_mem_size", mem_size, 0);
    checkVal("rst_aok", {inst_addr_ok, data_addr_ok}, 0);
    // single fetch read
    tick;
    inst_req = 1;
    inst_addr = 32'hBFC00000;
    #4;
    checkVal("t1_inst_addr_ok", inst_addr_ok, 1);
    checkVal("t1_mem_req_c0", mem_req, 0);
    tick;
    inst_req = 0;
    mem_addr_ok = 1;
    #4;
    checkVal("t1_mem_req_c1", mem_req, 1);
    checkVal("t1_mem_addr", mem_addr, 32'hBFC00000);
    checkVal("t1_mem_size", mem_size, 2);
    checkVal("t1_mem_wr", mem_wr, 0);
    checkVal("t1_busy", busy, 1);
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    mem_rdata = 32'h3C1D0000;
    #4;
    checkVal("t1_mem_req_c2", mem_req, 0);
    checkVal("t1_inst_data_ok", inst_data_ok, 1);
    checkVal("t1_inst_rdata", inst_rdata, 32'h3C1D0000);
    checkVal("t1_data_data_ok", data_data_ok, 0);
    checkVal("t1_data_rdata", data_rdata, 0);
    tick;
    mem_data_ok = 0;
    #4;
    checkVal("t1_busy_end", busy, 0);
    // collision: data first, then fetch
    tick;
    inst_req = 1;
    inst_addr = 32'hBFC00004;
    data_req = 1;
    data_wr = 1;
    data_size = 0;
    data_addr = 32'h80001003;
    data_wdata = 32'hAB;
    #4;
    checkVal("t2_data_addr_ok", data_addr_ok, 1);
    checkVal("t2_inst_addr_ok", inst_addr_ok, 0);
    tick;
    data_req = 0;
    mem_addr_ok = 1;
    #4;
    checkVal("t2_mem_wr", mem_wr, 1);
    checkVal("t2_mem_size", mem_size, 0);
    checkVal("t2_mem_addr", mem_addr, 32'h80001003);
    checkVal("t2_mem_wdata", mem_wdata, 32'hAB);
    checkVal("t2_inst_wait", inst_addr_ok, 0);
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    mem_rdata = 32'h12345678;
    #4;
    checkVal("t2_data_data_ok", data_data_ok, 1);
    checkVal("t2_inst_rdata", inst_rdata, 0);
    tick;
    mem_data_ok = 0;
    #4;
    checkVal("t2_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0;
    mem_addr_ok = 1;
    #4;
    checkVal("t2_i_mem_addr", mem_addr, 32'hBFC00004);
    checkVal("t2_i_mem_wr", mem_wr, 0);
    checkVal("t2_i_mem_size", mem_size, 2);
    checkVal("t2_i_mem_wdata", mem_wdata, 0);
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    #4;
    checkVal("t2_inst_data_ok", inst_data_ok, 1);
    tick;
    mem_data_ok = 0;
    // starvation bound: D,D,D,D,I repeating
    inst_req = 1;
    data_req = 1;
    data_wr = 0;
    for (int i = 0; i < 10; i++) runTxn($sformatf("t3_%0d", i), (i % 5) != 4);
    inst_req = 0;
    data_req = 0;
    tick;
    // slow downstream with a spurious response while in REQ
    data_req = 1;
    data_size = 2;
    data_addr = 32'h1000;
    #4;
    checkVal("t4_data_addr_ok", data_addr_ok, 1);
    tick;
    data_req = 0;
    inst_req = 1;
    for (int i = 0; i < 10; i++) begin
      mem_data_ok = (i == 5);
      #4;
      checkVal($sformatf("t4_mem_req_%0d", i), mem_req, 1);
      checkVal($sformatf("t4_mem_addr_%0d", i), mem_addr, 32'h1000);
      checkVal($sformatf("t4_mem_size_%0d", i), mem_size, 2);
      checkVal($sformatf("t4_aok_%0d", i), {inst_addr_ok, data_addr_ok}, 0);
      checkVal($sformatf("t4_dok_%0d", i), {inst_data_ok, data_data_ok}, 0);
      tick;
    end
    mem_data_ok = 0;
    mem_addr_ok = 1;
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    mem_rdata = 32'hCAFEF00D;
    #4;
    checkVal("t4_data_data_ok", data_data_ok, 1);
    checkVal("t4_data_rdata", data_rdata, 32'hCAFEF00D);
    tick;
    mem_data_ok = 0;
    #4;
    checkVal("t4_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0;
    mem_addr_ok = 1;
    tick;
    mem_addr_ok = 0;
    mem_data_ok = 1;
    tick;
    mem_data_ok = 0;
    // spurious handshakes in IDLE
    mem_data_ok = 1;
    mem_addr_ok = 1;
    #4;
    checkVal("t5_idle_dok", {inst_data_ok, data_data_ok}, 0);
    tick;
    mem_data_ok = 0;
    mem_addr_ok = 0;
    #4;
    checkVal("t5_idle_busy", busy, 0);
    checkVal("t5_idle_mem_req", mem_req, 0);
    // reset while in WAIT, starve counter previously nonzero
    tick;
    inst_req = 1;
    data_req = 1;
    #4;
    checkVal("t6_data_addr_ok", data_addr_ok, 1);
    tick;
    data_req = 0;
    mem_addr_ok = 1;
    tick;
    mem_addr_ok = 0;
    rst = 1;
    #4;
    checkVal("t6_busy_wait", busy, 1);
    tick;
    rst = 0;
    inst_req = 0;
    mem_data_ok = 1;
    #4;
    checkVal("t6_busy", busy, 0);
    checkVal("t6_mem_req", mem_req, 0);
    checkVal("t6_late_dok", {inst_data_ok, data_data_ok}, 0);
    tick;
    mem_data_ok = 0;
    inst_req = 1;
    data_req = 1;
    for (int i = 0; i < 5; i++) runTxn($sformatf("t6_%0d", i), i != 4);
    inst_req = 0;
    data_req = 0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
